data_sync: RTL and testbench
============================

DATA_SYNC -- requirements
Module: data_sync

Interface
REQ-001 Parameter BUS_WIDTH, default 8: width of the unsynchronised data bus.
REQ-002 Parameter NUM_STAGES, default 2: flop stages on the enable path; legal range 2..8.
REQ-003 Parameter TOGGLE_MODE, default 0: 0 = level enable (rising edge is the event); 1 = toggle enable (either edge is the event).
REQ-004 Parameter CNT_WIDTH, default 8: width of the event counter.
REQ-005 CLK  input  1: destination clock; one clock only; all flops on rising edge.
REQ-006 RST  input  1: reset, asynchronous, active-low.
REQ-007 unsync_bus  input  BUS_WIDTH: source-domain data, held stable by the source while enable is asserted.
REQ-008 bus_enable  input  1: source-domain qualifier, asynchronous to CLK.
REQ-009 clr_err  input  1: synchronous clear of bus_err, active-high.
REQ-010 sync_bus  output  BUS_WIDTH: captured data, registered.
REQ-011 enable_pulse  output  1: one-cycle strobe, high in the cycle sync_bus updates, registered.
REQ-012 evt_cnt  output  CNT_WIDTH: count of captures, saturating, registered.
REQ-013 bus_err  output  1: sticky flag for a bus stability violation, registered.

Function
REQ-014 The bus_enable signal SHALL pass through a NUM_STAGES flop chain; the last stage is en_sync.
REQ-015 One further flop SHALL hold en_sync_d, the value of en_sync delayed by one cycle.
REQ-016 The event condition SHALL be en_sync & ~en_sync_d when TOGGLE_MODE=0, and en_sync ^ en_sync_d when TOGGLE_MODE=1.
REQ-017 The unsync_bus signal SHALL be sampled only through the capture mux, never through a synchroniser chain.
REQ-018 On an edge where the event condition holds, sync_bus SHALL load unsync_bus; otherwise sync_bus SHALL hold its value.
REQ-019 The enable_pulse output SHALL equal the registered event condition: high exactly one cycle per event.
REQ-020 Latency: bus_enable sampled high at edge 1 gives en_sync high after edge NUM_STAGES, and sync_bus/enable_pulse updated at edge NUM_STAGES+1.
REQ-021 In level mode, bus_enable held high for many cycles SHALL produce exactly one pulse; a new pulse requires a low level to reach en_sync first.
REQ-022 On each capture, evt_cnt SHALL increment by one, saturating at 2^CNT_WIDTH-1 with no wrap.
REQ-023 Stability check: one edge after a capture, the block SHALL compare unsync_bus with sync_bus; any mismatch SHALL set bus_err.
REQ-024 The bus_err flag SHALL remain set until reset or until clr_err is sampled high.
REQ-025 When a mismatch and clr_err occur in the same cycle, set SHALL win and bus_err SHALL stay 1.
REQ-026 A new event in the stability-check cycle SHALL still capture, and the check SHALL use the pre-capture sync_bus.

Reset
REQ-027 While RST=0, all synchroniser stages, en_sync_d, sync_bus, enable_pulse, evt_cnt, bus_err and the check-pending flag SHALL be 0, immediately and asynchronously.
REQ-028 Reset mid-operation SHALL abort any pending check; no pulse or capture SHALL be produced from pre-reset state.
REQ-029 If bus_enable is 1 at reset release, one event SHALL occur at edge NUM_STAGES+1 after release in either mode.

Structure
REQ-030 A shared package SHALL hold the parameter legal-range constants and the mode encoding (LEVEL=0, TOGGLE=1).
REQ-031 The block SHALL use one sub-module, pulse_gen, containing the en_sync_d flop and the mode-selected event logic.
REQ-032 Capture, counter and check logic SHALL reside in data_sync.

Verification
REQ-033 NUM_STAGES=2, level mode, unsync_bus=0xA5, bus_enable raised -> enable_pulse high one cycle at edge 3, sync_bus=0xA5, evt_cnt=1.
REQ-034 Level mode, bus_enable held high 20 cycles -> exactly one pulse; after low and high again, second pulse with evt_cnt=2.
REQ-035 TOGGLE_MODE=1, bus_enable toggled 0->1->0 with 10-cycle gaps, bus 0x11 then 0x22 -> two pulses, sync_bus=0x11 then 0x22.
REQ-036 Bus changes 0x3C->0x3D the cycle after capture -> bus_err=1 and sticky; clr_err pulse -> 0; mismatch concurrent with clr_err -> stays 1.
REQ-037 CNT_WIDTH=4, 17 events -> evt_cnt saturates at 15.
REQ-038 RST asserted between edge 1 and edge NUM_STAGES of an event -> all outputs 0 immediately, no pulse after release while bus_enable=0.

Source files
------------

// File: rtl/data_sync_pkg.sv
// Shared constants for the data_sync block: legal synchroniser depth and
// the enable-mode encoding used to pick the event condition.
package data_sync_pkg;

    localparam int NUM_STAGES_MIN = 2;
    localparam int NUM_STAGES_MAX = 8;

    typedef enum logic {
        LEVEL  = 1'b0,
        TOGGLE = 1'b1
    } en_mode_e;

    // Level mode fires on a rising edge of the synchronised enable, toggle mode on any edge.
    function automatic logic event_cond(en_mode_e mode, logic cur, logic prev);
        return (mode == TOGGLE) ? (cur ^ prev) : (cur & ~prev);
    endfunction

endpackage

// File: rtl/data_sync_pulse_gen.sv
// Edge detector on the synchronised enable: holds the one-cycle-delayed copy
// and produces the mode-selected event condition.
module pulse_gen
    import data_sync_pkg::*;
#(
    parameter en_mode_e MODE = LEVEL
) (
    input  logic CLK,
    input  logic RST,
    input  logic en_sync,
    output logic evt
);

    logic en_sync_d;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            en_sync_d <= 1'b0;
        end else begin
            en_sync_d <= en_sync;
        end
    end

    assign evt = event_cond(MODE, en_sync, en_sync_d);

endmodule

// File: rtl/data_sync.sv
// Enable-qualified bus synchroniser: the enable crosses through a flop chain,
// and the bus is captured directly when the synchronised enable shows an event.
module data_sync
    import data_sync_pkg::*;
#(
    parameter int BUS_WIDTH   = 8,
    parameter int NUM_STAGES  = 2,
    parameter int TOGGLE_MODE = 0,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [BUS_WIDTH-1:0] unsync_bus,
    input  logic                 bus_enable,
    input  logic                 clr_err,
    output logic [BUS_WIDTH-1:0] sync_bus,
    output logic                 enable_pulse,
    output logic [CNT_WIDTH-1:0] evt_cnt,
    output logic                 bus_err
);

    // Handshake: bus_enable qualifies unsync_bus. The source holds the bus stable
    // while enable is asserted; each event captures once, there is no backpressure.

    localparam en_mode_e MODE = (TOGGLE_MODE != 0) ? TOGGLE : LEVEL;

    if (NUM_STAGES < NUM_STAGES_MIN || NUM_STAGES > NUM_STAGES_MAX) begin : g_bad_stages
        $error("data_sync: NUM_STAGES out of range");
    end

    logic [NUM_STAGES-1:0] sync_q;
    logic                  en_sync;
    logic                  evt;
    logic                  chk_pend;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[NUM_STAGES-2:0], bus_enable};
        end
    end

    assign en_sync = sync_q[NUM_STAGES-1];

    pulse_gen #(
        .MODE (MODE)
    ) u_pulse_gen (
        .CLK     (CLK),
        .RST     (RST),
        .en_sync (en_sync),
        .evt     (evt)
    );

    // The stability check compares against the current sync_bus, so a capture
    // landing in the same cycle is checked against the pre-capture value.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync_bus     <= '0;
            enable_pulse <= 1'b0;
            evt_cnt      <= '0;
            bus_err      <= 1'b0;
            chk_pend     <= 1'b0;
        end else begin
            enable_pulse <= evt;
            chk_pend     <= evt;
            if (evt) begin
                sync_bus <= unsync_bus;
                if (evt_cnt != {CNT_WIDTH{1'b1}}) begin
                    evt_cnt <= evt_cnt + CNT_WIDTH'(1);
                end
            end
            if (chk_pend && (unsync_bus != sync_bus)) begin
                bus_err <= 1'b1;
            end else if (clr_err) begin
                bus_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_data_sync.sv
// Bench for data_sync: three configurations driven by shared stimulus and checked
// every cycle against a delay-line reference model, plus directed spot values.
module tb_data_sync;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] unsync_bus;
    logic       bus_enable;
    logic       clr_err;

    logic [7:0] sb_l, sb_t, sb_s;
    logic       ep_l, ep_t, ep_s;
    logic [7:0] cnt_l, cnt_t;
    logic [3:0] cnt_s;
    logic       err_l, err_t, err_s;

    int passed = 0;
    int total  = 0;

    // Reference model state, index 0 = level/NS2, 1 = toggle/NS3, 2 = level/NS2/CNT4
    int         ns_m[3]   = '{2, 3, 2};
    bit         tgl_m[3]  = '{1'b0, 1'b1, 1'b0};
    int         cmax_m[3] = '{255, 255, 15};
    logic [7:0] m_sync[3];
    bit         m_pulse[3];
    int         m_cnt[3];
    bit         m_err[3];
    bit         hist[$];

    always #5 CLK = ~CLK;

    data_sync #(.BUS_WIDTH(8), .NUM_STAGES(2), .TOGGLE_MODE(0), .CNT_WIDTH(8)) dut_lvl (
        .CLK(CLK), .RST(RST), .unsync_bus(unsync_bus), .bus_enable(bus_enable), .clr_err(clr_err),
        .sync_bus(sb_l), .enable_pulse(ep_l), .evt_cnt(cnt_l), .bus_err(err_l));

    data_sync #(.BUS_WIDTH(8), .NUM_STAGES(3), .TOGGLE_MODE(1), .CNT_WIDTH(8)) dut_tgl (
        .CLK(CLK), .RST(RST), .unsync_bus(unsync_bus), .bus_enable(bus_enable), .clr_err(clr_err),
        .sync_bus(sb_t), .enable_pulse(ep_t), .evt_cnt(cnt_t), .bus_err(err_t));

    data_sync #(.BUS_WIDTH(8), .NUM_STAGES(2), .TOGGLE_MODE(0), .CNT_WIDTH(4)) dut_sat (
        .CLK(CLK), .RST(RST), .unsync_bus(unsync_bus), .bus_enable(bus_enable), .clr_err(clr_err),
        .sync_bus(sb_s), .enable_pulse(ep_s), .evt_cnt(cnt_s), .bus_err(err_s));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        hist.delete();
        for (int k = 0; k < 10; k++) hist.push_back(1'b0);
        for (int i = 0; i < 3; i++) begin
            m_sync[i]  = 8'h00;
            m_pulse[i] = 1'b0;
            m_cnt[i]   = 0;
            m_err[i]   = 1'b0;
        end
    endtask

    // Event at edge m is decided by the enable values sampled at edges m-NS and m-NS-1.
    task automatic model_edge();
        bit a, p, ev, mism;
        if (!RST) return;
        hist.push_back(bus_enable);
        if (hist.size() > 16) void'(hist.pop_front());
        for (int i = 0; i < 3; i++) begin
            a    = hist[hist.size() - 1 - ns_m[i]];
            p    = hist[hist.size() - 2 - ns_m[i]];
            ev   = tgl_m[i] ? (a != p) : (a && !p);
            mism = m_pulse[i] && (unsync_bus != m_sync[i]);
            if (mism) m_err[i] = 1'b1;
            else if (clr_err) m_err[i] = 1'b0;
            if (ev) begin
                m_sync[i] = unsync_bus;
                if (m_cnt[i] < cmax_m[i]) m_cnt[i]++;
            end
            m_pulse[i] = ev;
        end
    endtask

    task automatic check_all();
        chk("sync_bus_lvl", 32'(sb_l), 32'(m_sync[0]));
        chk("pulse_lvl", 32'(ep_l), 32'(m_pulse[0]));
        chk("cnt_lvl", 32'(cnt_l), 32'(m_cnt[0]));
        chk("err_lvl", 32'(err_l), 32'(m_err[0]));
        chk("sync_bus_tgl", 32'(sb_t), 32'(m_sync[1]));
        chk("pulse_tgl", 32'(ep_t), 32'(m_pulse[1]));
        chk("cnt_tgl", 32'(cnt_t), 32'(m_cnt[1]));
        chk("err_tgl", 32'(err_t), 32'(m_err[1]));
        chk("sync_bus_sat", 32'(sb_s), 32'(m_sync[2]));
        chk("pulse_sat", 32'(ep_s), 32'(m_pulse[2]));
        chk("cnt_sat", 32'(cnt_s), 32'(m_cnt[2]));
        chk("err_sat", 32'(err_s), 32'(m_err[2]));
    endtask

    // One rising edge: advance the model with the sampled inputs, check 1 time unit later.
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            model_edge();
            #1;
            check_all();
        end
    endtask

    // Assert reset between edges, check the immediate clear, then release mid-cycle.
    task automatic async_reset(input logic en_at_release);
        #2;
        RST = 1'b0;
        model_reset();
        #1;
        check_all();
        bus_enable = en_at_release;
        step(2);
        #2;
        RST = 1'b1;
    endtask

    initial begin
        RST        = 1'b0;
        unsync_bus = 8'h00;
        bus_enable = 1'b0;
        clr_err    = 1'b0;
        model_reset();
        #3;
        check_all();
        step(3);
        #2;
        RST = 1'b1;
        step(4);

        // Single level-mode capture with its exact latency
        unsync_bus = 8'hA5;
        bus_enable = 1'b1;
        step(2);
        chk("lvl_no_pulse_edge2", 32'(ep_l), 32'd0);
        step(1);
        chk("lvl_pulse_edge3", 32'(ep_l), 32'd1);
        chk("lvl_sync_a5", 32'(sb_l), 32'hA5);
        chk("lvl_cnt_1", 32'(cnt_l), 32'd1);
        step(1);
        chk("lvl_pulse_one_cycle", 32'(ep_l), 32'd0);

        // Long high level gives no further pulse; a low then high gives the second
        step(20);
        chk("lvl_cnt_after_hold", 32'(cnt_l), 32'd1);
        bus_enable = 1'b0;
        step(5);
        unsync_bus = 8'h5A;
        bus_enable = 1'b1;
        step(3);
        chk("lvl_pulse_second", 32'(ep_l), 32'd1);
        chk("lvl_cnt_2", 32'(cnt_l), 32'd2);

        // Bus changing right after capture sets the sticky error
        bus_enable = 1'b0;
        step(6);
        unsync_bus = 8'h3C;
        bus_enable = 1'b1;
        step(3);
        chk("lvl_sync_3c", 32'(sb_l), 32'h3C);
        unsync_bus = 8'h3D;
        step(1);
        chk("lvl_err_set", 32'(err_l), 32'd1);
        step(5);
        chk("lvl_err_sticky", 32'(err_l), 32'd1);
        clr_err = 1'b1;
        step(1);
        clr_err = 1'b0;
        chk("lvl_err_cleared", 32'(err_l), 32'd0);
        bus_enable = 1'b0;
        step(6);
        unsync_bus = 8'h3C;
        bus_enable = 1'b1;
        step(3);
        unsync_bus = 8'h3D;
        clr_err    = 1'b1;
        step(1);
        clr_err = 1'b0;
        chk("lvl_err_set_wins", 32'(err_l), 32'd1);

        // Counter saturation on the 4-bit instance
        for (int k = 0; k < 40; k++) begin
            bus_enable = ~bus_enable;
            step(4);
        end
        chk("sat_cnt_15", 32'(cnt_s), 32'd15);

        // Reset between edge 1 and edge NS of an event: nothing survives it
        bus_enable = 1'b0;
        step(6);
        bus_enable = 1'b1;
        step(1);
        async_reset(1'b0);
        chk("rst_sync_zero", 32'(sb_l), 32'd0);
        step(8);
        chk("rst_no_pulse_cnt", 32'(cnt_l), 32'd0);

        // Toggle mode: both edges of the enable capture
        unsync_bus = 8'h11;
        bus_enable = 1'b1;
        step(10);
        chk("tgl_sync_11", 32'(sb_t), 32'h11);
        unsync_bus = 8'h22;
        bus_enable = 1'b0;
        step(10);
        chk("tgl_sync_22", 32'(sb_t), 32'h22);
        chk("tgl_cnt_2", 32'(cnt_t), 32'd2);

        // Enable already high at reset release
        async_reset(1'b1);
        step(3);
        chk("rel_pulse_lvl", 32'(ep_l), 32'd1);
        step(1);
        chk("rel_pulse_tgl", 32'(ep_t), 32'd1);

        // Randomised traffic with an occasional asynchronous reset
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 3) == 0) bus_enable = ~bus_enable;
            if ($urandom_range(0, 4) == 0) unsync_bus = 8'($urandom_range(0, 255));
            clr_err = ($urandom_range(0, 9) == 0);
            if (k == 200) async_reset(1'($urandom_range(0, 1)));
            step(1);
        end
        clr_err = 1'b0;
        step(4);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
